// File: rtl/mux4_rr_arbiter_if.sv
// Handshake/data bundle between four requesters, the round-robin arbiter and the
// downstream consumer. The arbiter connects through the master modport; the
// requester/consumer side connects through the slave modport.
interface mux4_rr_arbiter_if #(
  parameter int unsigned DATA_W = 4
);
  logic [3:0]        req;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] data_c;
  logic [DATA_W-1:0] data_d;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        sel;
  logic [3:0]        gnt;

  // Arbiter side: sees requests/data/ready, drives the selected output and grant.
  modport master (
    input  req, data_a, data_b, data_c, data_d, out_ready,
    output out_valid, out_data, sel, gnt
  );

  // Requester/consumer side.
  modport slave (
    output req, data_a, data_b, data_c, data_d, out_ready,
    input  out_valid, out_data, sel, gnt
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a 4:1 mux datapath. Four requesters share one
// output; each grant is held for at most MAX_BURST accepted beats, then the owner
// goes to the back of the rotation. One IDLE cycle separates consecutive grants.
// Optional macro ARB_STATS_EN adds grant_cnt: four saturating 8-bit per-requester
// grant counters.
module mux4_rr_arbiter #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mux4_rr_arbiter_if.master     bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]           grant_cnt
`endif
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] beat_q, beat_d;

  logic [1:0]    win_c;
  logic          any_req_c;
  logic          valid_c;
  logic          beat_c;

  // Winner: first set request scanning last+1, last+2, ... (mod 4).
  always_comb begin
    win_c     = last_q;
    any_req_c = |bus.req;
    for (int i = 4; i >= 1; i--) begin
      if (bus.req[2'(last_q + 2'(i))]) win_c = 2'(last_q + 2'(i));
    end
  end

  // Output handshake: owner's request qualifies valid; data is a plain mux by sel.
  always_comb begin
    valid_c = (state_q == BUSY) && bus.req[sel_q];
    beat_c  = valid_c && bus.out_ready;
    unique case (sel_q)
      2'd0:    bus.out_data = bus.data_a;
      2'd1:    bus.out_data = bus.data_b;
      2'd2:    bus.out_data = bus.data_c;
      default: bus.out_data = bus.data_d;
    endcase
  end

  assign bus.out_valid = valid_c;
  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;

  // Next-state: grant from IDLE, count beats and release from BUSY.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (any_req_c) begin
          gnt_d   = 4'(1) << win_c;
          sel_d   = win_c;
          beat_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!bus.req[sel_q]) begin
          // Owner withdrew (possibly abandoning an unaccepted beat).
          gnt_d   = 4'b0000;
          last_d  = sel_q;
          state_d = IDLE;
        end else if (beat_c) begin
          if (beat_q == LAST_BEAT) begin
            gnt_d   = 4'b0000;
            last_d  = sel_q;
            state_d = IDLE;
          end else begin
            beat_d = CW'(beat_q + 1'b1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State register; reset puts A at top priority (last = D).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [7:0] cnt_q [4];

  // Per-requester grant counters, bumped on each IDLE->BUSY grant, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
    end else if ((state_q == IDLE) && any_req_c && (cnt_q[win_c] != 8'hFF)) begin
      cnt_q[win_c] <= 8'(cnt_q[win_c] + 8'd1);
    end
  end

  assign grant_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a driver advances a behavioural model each
// cycle and queues the expected outputs; a monitor pops and compares at negedge.
module tb_mux4_rr_arbiter;

  localparam int DW   = 4;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic reset;

  mux4_rr_arbiter_if #(.DATA_W(DW)) bus ();

`ifdef ARB_STATS_EN
  logic [31:0] grant_cnt;
`endif

  mux4_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          vld;
    logic [DW-1:0] data;
    logic [31:0]   gc;
    string         tag;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  // Reference model: who owns the output, how many beats it has had, who went last.
  int owner;
  int last_w;
  int sel_m;
  int beats;
  int gcnt[4];
  string phase = "init";

  function automatic logic [DW-1:0] data_of(input int i);
    case (i)
      0: return bus.data_a;
      1: return bus.data_b;
      2: return bus.data_c;
      default: return bus.data_d;
    endcase
  endfunction

  // Apply one clock edge to the model using the inputs that were present at it.
  task automatic model_edge();
    if (reset) begin
      owner = -1; last_w = 3; sel_m = 0; beats = 0;
      for (int i = 0; i < 4; i++) gcnt[i] = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int w;
        w = (last_w + k) % 4;
        if (owner < 0 && bus.req[w]) begin
          owner = w; sel_m = w; beats = 0;
          if (gcnt[w] < 255) gcnt[w]++;
        end
      end
    end else if (!bus.req[owner]) begin
      last_w = owner; owner = -1;
    end else if (bus.out_ready) begin
      beats++;
      if (beats == MAXB) begin
        last_w = owner; owner = -1;
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.gnt  = (owner < 0) ? 4'b0000 : 4'(1 << owner);
    e.sel  = 2'(sel_m);
    e.vld  = (owner >= 0) && bus.req[owner];
    e.data = data_of(sel_m);
    e.gc   = {8'(gcnt[3]), 8'(gcnt[2]), 8'(gcnt[1]), 8'(gcnt[0])};
    e.tag  = phase;
    exp_q.push_back(e);
  endtask

  // One cycle: edge, model update, drive new inputs, queue expectation.
  task automatic cycle(input logic rst, input logic [3:0] r, input logic rdy);
    @(posedge clk);
    model_edge();
    #1;
    reset         = rst;
    bus.req       = r;
    bus.out_ready = rdy;
    bus.data_a    = DW'($urandom);
    bus.data_b    = DW'($urandom);
    bus.data_c    = DW'($urandom);
    bus.data_d    = DW'($urandom);
    push_expected();
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.gnt !== e.gnt) begin
          failures++;
          $display("FAIL %s gnt: got %b want %b at %0t", e.tag, bus.gnt, e.gnt, $time);
        end
        checks++;
        if (bus.sel !== e.sel) begin
          failures++;
          $display("FAIL %s sel: got %0d want %0d at %0t", e.tag, bus.sel, e.sel, $time);
        end
        checks++;
        if (bus.out_valid !== e.vld) begin
          failures++;
          $display("FAIL %s out_valid: got %b want %b at %0t", e.tag, bus.out_valid, e.vld, $time);
        end
        checks++;
        if (bus.out_data !== e.data) begin
          failures++;
          $display("FAIL %s out_data: got %h want %h at %0t", e.tag, bus.out_data, e.data, $time);
        end
`ifdef ARB_STATS_EN
        checks++;
        if (grant_cnt !== e.gc) begin
          failures++;
          $display("FAIL %s grant_cnt: got %h want %h at %0t", e.tag, grant_cnt, e.gc, $time);
        end
`endif
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized soak.
  initial begin
    logic [3:0] r;
    reset = 1'b1; bus.req = 4'hF; bus.out_ready = 1'b1;
    bus.data_a = '0; bus.data_b = '0; bus.data_c = '0; bus.data_d = '0;
    owner = -1; last_w = 3; sel_m = 0; beats = 0;
    for (int i = 0; i < 4; i++) gcnt[i] = 0;

    phase = "reset";
    for (int i = 0; i < 2; i++) cycle(1'b1, 4'hF, 1'b1);

    phase = "single_b";
    for (int i = 0; i < 14; i++) cycle(1'b0, 4'b0010, 1'b1);

    phase = "backpressure";
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0010, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0010, 1'b1);

    phase = "round_robin";
    cycle(1'b1, 4'h0, 1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b0, 4'hF, 1'b1);

    phase = "early_drop";
    cycle(1'b1, 4'h0, 1'b1);
    cycle(1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1101, 1'b1);
    for (int i = 0; i < 14; i++) cycle(1'b0, 4'b1001, 1'b1);

    phase = "reset_mid";
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'b1000, 1'b1);
    cycle(1'b0, 4'b1000, 1'b1);
    cycle(1'b1, 4'b1000, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'hF, 1'b1);

    phase = "saturate";
    for (int i = 0; i < 1350; i++) cycle(1'b0, 4'b0010, 1'b1);

    phase = "random";
    r = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
      cycle(($urandom_range(149) == 0), r, ($urandom_range(9) < 7));
    end

    cycle(1'b0, 4'h0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    done = 1'b1;
  end

  // Global time bound so the run always terminates with a summary.
  initial begin
    for (int i = 0; i < 20000 && !done; i++) @(posedge clk);
    if (!done) begin
      failures++;
      $display("FAIL timeout: stimulus did not complete within cycle budget");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
